// File: rtl/aes_out_pkg.sv
// Shared constants, FSM state and beat-index types for the AES output stage.
package aes_out_pkg;

  localparam int unsigned BLK_W  = 128;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned BEATS  = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  typedef logic [1:0] beat_t;

  // Even parity per byte: bit i covers w[8i+7:8i].
  function automatic logic [3:0] byte_parity(input logic [31:0] w);
    logic [3:0] p;
    p = '0;
    for (int i = 0; i < 4; i++) begin
      p[i] = ^w[8*i +: 8];
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_out_fifo.sv
// DEPTH x 128-bit block buffer; a push on a full buffer is accepted when the
// head pops in the same cycle.
module aes_out_fifo
  import aes_out_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push_req,
  input  logic [BLK_W-1:0] i_data,
  input  logic             i_pop,
  output logic             o_ready,
  output logic [BLK_W-1:0] o_head,
  output logic             o_empty,
  output logic             o_empty_nxt
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [BLK_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_push;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign o_ready     = (r_count < CNT_W'(DEPTH)) || i_pop;
  assign w_push      = i_push_req && o_ready;
  assign o_head      = r_mem[r_rd_ptr];
  assign o_empty     = (r_count == '0);
  assign o_empty_nxt = (w_count_nxt == '0);

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, i_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_count <= w_count_nxt;
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (i_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
    end
  end

  // Storage needs no reset: reads are only observed while the stage is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/aes_out_stage.sv
// Buffers 128-bit cipher results and serializes them MSB-first as 32-bit beats.
// Optional per-byte parity output enabled by macro AES_OUT_PARITY_EN.
module aes_out_stage #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned WORD_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [4*WORD_W-1:0] in_data,
  output logic                in_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORD_W-1:0]   out_data,
  output logic [1:0]          out_beat,
  output logic                out_last,
`ifdef AES_OUT_PARITY_EN
  output logic [3:0]          out_par,
`endif
  output logic                overflow,
  output logic                busy
);

  import aes_out_pkg::*;

  state_t           r_state;
  state_t           w_state_nxt;
  beat_t            r_beat;
  logic             r_overflow;
  logic             w_hs;
  logic             w_pop;
  logic             w_empty;
  logic             w_empty_nxt;
  logic [BLK_W-1:0] w_head;

  aes_out_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push_req  (in_valid),
    .i_data      (in_data),
    .i_pop       (w_pop),
    .o_ready     (in_ready),
    .o_head      (w_head),
    .o_empty     (w_empty),
    .o_empty_nxt (w_empty_nxt)
  );

  assign w_hs  = out_valid && out_ready;
  assign w_pop = w_hs && out_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Entering SEND on the push edge gives beat0 the cycle after a push.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (!w_empty_nxt)          w_state_nxt = ST_SEND;
      ST_SEND: if (w_pop && w_empty_nxt)  w_state_nxt = ST_IDLE;
      default:                            w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    out_valid = (r_state == ST_SEND);
    out_beat  = 2'd0;
    out_last  = 1'b0;
    out_data  = '0;
    if (out_valid) begin
      out_beat = r_beat;
      out_last = (r_beat == beat_t'(BEATS - 1));
      case (r_beat)
        2'd0:    out_data = w_head[127:96];
        2'd1:    out_data = w_head[95:64];
        2'd2:    out_data = w_head[63:32];
        default: out_data = w_head[31:0];
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_hs) r_beat <= r_beat + beat_t'(1);
      if (in_valid && !in_ready) r_overflow <= 1'b1;
    end
  end

  assign overflow = r_overflow;
  assign busy     = !w_empty || (r_state == ST_SEND);

`ifdef AES_OUT_PARITY_EN
  assign out_par = byte_parity(out_data);
`endif

endmodule

// File: tb/tb_aes_out_stage.sv
// Scoreboard bench for aes_out_stage: cycle-level block/beat model plus a decoupled beat monitor.
module tb_aes_out_stage;

  localparam int unsigned DEPTH = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [127:0] in_data = '0;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [31:0]  out_data;
  logic [1:0]   out_beat;
  logic         out_last;
  logic         overflow;
  logic         busy;
`ifdef AES_OUT_PARITY_EN
  logic [3:0]   out_par;
`endif

  aes_out_stage #(.DEPTH(DEPTH), .WORD_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_beat  (out_beat),
    .out_last  (out_last),
`ifdef AES_OUT_PARITY_EN
    .out_par   (out_par),
`endif
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  beat;
    logic        last;
  } beat_exp_t;

  beat_exp_t exp_q[$];
  int checks   = 0;
  int failures = 0;
  int hs_seen  = 0;
  int m_n      = 0;   // blocks held in the stage
  int m_b      = 0;   // next beat of the head block
  bit m_ovf    = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] ref_par(input logic [31:0] w);
    logic [3:0] p;
    for (int i = 0; i < 4; i++) p[i] = ($countones(w >> (8 * i)) - $countones(w >> (8 * i + 8))) % 2 != 0;
    return p;
  endfunction

  // Monitor: the queue head must match whatever the DUT presents; pop on handshake.
  initial forever begin
    @(negedge clk);
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 128'(out_data), 128'(0));
      end else begin
        chk("out_data", 128'(out_data), 128'(exp_q[0].data));
        chk("out_beat", 128'(out_beat), 128'(exp_q[0].beat));
        chk("out_last", 128'(out_last), 128'(exp_q[0].last));
`ifdef AES_OUT_PARITY_EN
        chk("out_par", 128'(out_par), 128'(ref_par(exp_q[0].data)));
`endif
        if (out_ready) begin
          void'(exp_q.pop_front());
          hs_seen++;
        end
      end
    end
  end

  // One cycle of stimulus; called right after a rising edge.
  task automatic step(input bit iv, input logic [127:0] d, input bit rdy);
    bit valid, room, hs, pop;
    beat_exp_t e;
    in_valid  = iv;
    in_data   = d;
    out_ready = rdy;
    @(negedge clk);
    valid = (m_n > 0);
    hs    = valid && rdy;
    pop   = hs && (m_b == 3);
    room  = (m_n < DEPTH) || pop;
    chk("out_valid", 128'(out_valid), 128'(valid));
    chk("in_ready", 128'(in_ready), 128'(room));
    chk("busy", 128'(busy), 128'(valid));
    chk("overflow", 128'(overflow), 128'(m_ovf));
    if (hs) m_b = (m_b + 1) % 4;
    if (pop) m_n--;
    if (iv && room) begin
      m_n++;
      for (int k = 0; k < 4; k++) begin
        e.data = 32'(d >> (96 - 32 * k));
        e.beat = 2'(k);
        e.last = (k == 3);
        exp_q.push_back(e);
      end
    end else if (iv) begin
      m_ovf = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_data", 128'(out_data), 128'(0));
    chk("rst_out_beat", 128'(out_beat), 128'(0));
    chk("rst_out_last", 128'(out_last), 128'(0));
    chk("rst_overflow", 128'(overflow), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));
`ifdef AES_OUT_PARITY_EN
    chk("rst_out_par", 128'(out_par), 128'(0));
`endif
    m_n = 0;
    m_b = 0;
    m_ovf = 1'b0;
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, '0, rdy);
  endtask

  function automatic logic [127:0] rnd_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  localparam logic [127:0] KAT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  initial begin
    int h0;
    @(posedge clk);
    #1;
    do_reset();

    // Single known block, streamed back-to-back.
    step(1'b1, KAT, 1'b1);
    idle(6, 1'b1);

    // Backpressure at beat1 for 5 cycles.
    step(1'b1, KAT, 1'b1);
    idle(1, 1'b1);
    idle(5, 1'b0);
    idle(5, 1'b1);

    // Overflow: third push into a full, stalled buffer is dropped.
    do_reset();
    h0 = hs_seen;
    step(1'b1, rnd_blk(), 1'b0);
    step(1'b1, rnd_blk(), 1'b0);
    step(1'b1, rnd_blk(), 1'b0);
    idle(12, 1'b1);
    chk("beats_after_overflow", 128'(hs_seen - h0), 128'(8));

    // Full buffer: push coincides with the beat-3 handshake.
    do_reset();
    step(1'b1, rnd_blk(), 1'b0);
    step(1'b1, rnd_blk(), 1'b0);
    idle(3, 1'b1);
    step(1'b1, rnd_blk(), 1'b1);
    idle(10, 1'b1);

    // Reset while beat2 is on the bus, then a fresh block.
    step(1'b1, rnd_blk(), 1'b1);
    idle(2, 1'b1);
    do_reset();
    step(1'b1, KAT, 1'b1);
    idle(6, 1'b1);

    // Random traffic with occasional resets.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 249) == 0) do_reset();
      step($urandom_range(0, 2) == 0, rnd_blk(), $urandom_range(0, 3) != 0);
    end
    idle(4 * DEPTH + 4, 1'b1);
    chk("drained", 128'(exp_q.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
